// File: rtl/key_pkg.sv
// Shared definitions for the key front-end: press FSM encoding and counter sizing.
package key_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  // Bits needed to hold 0..maxv, never less than one.
  function automatic int cnt_w(input int maxv);
    return (maxv < 1) ? 1 : $clog2(maxv + 1);
  endfunction

endpackage

// File: rtl/key_channel.sv
// One button: 2-FF synchroniser, debounce counter and press/auto-repeat FSM.
// pulse is combinational so the top's output register lands it at D+2 edges after the press.
module key_channel
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic db,
  output logic pulse
);

  localparam int CW   = cnt_w(DEBOUNCE_CYCLES - 1);
  localparam int TMAX = ((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD) - 1;
  localparam int TW   = cnt_w(TMAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] DLY_LAST = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PER_LAST = TW'(REPEAT_PERIOD - 1);

  logic          s1, s2;
  logic [CW-1:0] cnt;
  logic          db_nxt;
  logic [1:0]    state;
  logic [TW-1:0] tcnt;

  // Value db takes on this edge; lets the FSM drop to IDLE on the same edge db falls.
  assign db_nxt = ((s2 != db) && (cnt == CNT_LAST)) ? s2 : db;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      db  <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= key;
      s2 <= s1;
      if (s2 == db)
        cnt <= '0;
      else if (cnt == CNT_LAST) begin
        db  <= s2;
        cnt <= '0;
      end else
        cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    pulse = 1'b0;
    case (state)
      ST_IDLE:   pulse = db && db_nxt;
      ST_DELAY:  pulse = (REPEAT_EN != 0) && db && db_nxt && (tcnt == DLY_LAST);
      ST_REPEAT: pulse = db && db_nxt && (tcnt == PER_LAST);
      default:   pulse = 1'b0;
    endcase
  end

  // Timers saturate at their terminal count; with repeat disabled DELAY parks there.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      tcnt  <= '0;
    end else if (!db_nxt) begin
      state <= ST_IDLE;
      tcnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (db) begin
          state <= ST_DELAY;
          tcnt  <= '0;
        end
        ST_DELAY: if (pulse) begin
          state <= ST_REPEAT;
          tcnt  <= '0;
        end else if (tcnt != DLY_LAST)
          tcnt <= tcnt + 1'b1;
        ST_REPEAT: if (pulse)
          tcnt <= '0;
        else if (tcnt != PER_LAST)
          tcnt <= tcnt + 1'b1;
        default: begin
          state <= ST_IDLE;
          tcnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_pulse_gen.sv
// Two debounced key channels feeding registered, mutually exclusive inc/dec pulses.
module key_pulse_gen
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic key_inc,
  input  logic key_dec,
  output logic inc,
  output logic dec
);

  logic inc_db, inc_pulse, dec_db, dec_pulse;

  key_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_EN(REPEAT_EN),
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_inc (
    .clk(clk), .rst(rst), .key(key_inc), .db(inc_db), .pulse(inc_pulse)
  );

  key_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_EN(REPEAT_EN),
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_dec (
    .clk(clk), .rst(rst), .key(key_dec), .db(dec_db), .pulse(dec_pulse)
  );

  // A pulse implies its own db is high, so cross-gating keeps inc and dec exclusive.
  always_ff @(posedge clk) begin
    if (rst) begin
      inc <= 1'b0;
      dec <= 1'b0;
    end else begin
      inc <= inc_pulse & ~dec_db;
      dec <= dec_pulse & ~inc_db;
    end
  end

endmodule

// File: doc/key_pulse_gen.md
# key_pulse_gen

Front-end for the key-controlled PWM duty register. Takes the two raw push-button levels (increase, decrease) and turns them into clean single-cycle `inc`/`dec` pulses for the PWM register. Each button is synchronised, debounced, edge-detected and optionally auto-repeated while held. It sits directly upstream of the PWM register and drives its `inc`/`dec` inputs on the same clock.

## Interface

- DEBOUNCE_CYCLES, 4: consecutive stable cycles required before the debounced level changes (≥1)
- REPEAT_EN, 1: 1 = auto-repeat while held, 0 = one pulse per press
- REPEAT_DELAY, 16: cycles from first pulse to first repeat pulse (≥1)
- REPEAT_PERIOD, 8: cycles between subsequent repeat pulses (≥1)

- clk  in  1  single system clock; everything on rising edge
- rst  in  1  synchronous, active-high reset
- key_inc  in  1  raw, asynchronous, bouncy increase button (1 = pressed)
- key_dec  in  1  raw, asynchronous, bouncy decrease button (1 = pressed)
- inc  out  1  one-cycle increase pulse, registered
- dec  out  1  one-cycle decrease pulse, registered

## Operation

- Per key: 2-FF synchroniser (s1, s2), then debounce counter, then press FSM.
- Debounce: if s2 == db, cnt ← 0. Otherwise cnt increments. When the mismatch has held for DEBOUNCE_CYCLES consecutive edges, db ← s2 and cnt ← 0. A single agreeing cycle restarts the count.
- Counter widths are $clog2(max value + 1). Counters saturate and never wrap.
- FSM states and transitions:
  - IDLE: on a db 0→1 transition, emit a pulse and go to DELAY with tcnt ← 0.
  - DELAY: tcnt counts up. When tcnt reaches REPEAT_DELAY−1 with db still high, emit a pulse and go to REPEAT with tcnt ← 0.
  - REPEAT: same rule, using REPEAT_PERIOD−1, and stays in REPEAT.
  - From any state, db low → IDLE with no pulse.
  - With REPEAT_EN = 0, DELAY is held until release and no repeat pulses are emitted.
- Output gating: `inc` ← inc_pulse & ~dec_db and `dec` ← dec_pulse & ~inc_db.
  - While both debounced keys are high, neither output pulses, but both FSMs keep their timing.
  - `inc` and `dec` are never high in the same cycle.
- Release then re-press counts as a new press (IDLE → pulse), regardless of repeat timing.

## Timing

- Reset: s1, s2, db, cnt and tcnt are all 0, FSM is IDLE, and `inc` = `dec` = 0. Outputs are 0 in the cycle after any edge that samples rst = 1.
- Press latency: edge k is the first edge that samples raw = 1 with no bounce. Then:
  - db rises at edge k+1+DEBOUNCE_CYCLES.
  - The output pulse is high for exactly one cycle, following edge k+2+DEBOUNCE_CYCLES (k+6 at defaults).
- Release latency: db falls DEBOUNCE_CYCLES+2 edges after raw falls. The FSM enters IDLE on that same edge.
- Repeat spacing at the output: the first repeat pulse comes REPEAT_DELAY cycles after the initial pulse, then one every REPEAT_PERIOD cycles, with no jitter.
- Bounce shorter than DEBOUNCE_CYCLES produces no pulse and no db change.
- Reset mid-press: db restarts at 0. A key held through the reset deassertion is treated as a fresh press, with its pulse D+2 cycles after the first non-reset edge.

## Structure

- Shared package `key_pkg`: FSM state encoding (IDLE = 2'd0, DELAY = 2'd1, REPEAT = 2'd2) and a counter-width helper function.
- Sub-module `key_channel` (params DEBOUNCE_CYCLES, REPEAT_EN, REPEAT_DELAY, REPEAT_PERIOD; ports clk, rst, key, db, pulse) holds the synchroniser, debounce and FSM. It is instantiated twice.
- The top level contains only the two instances plus the gating and output registers.

## Test plan

All scenarios use default parameters and a 2-unit clock period.

- Clean press, held 10 cycles, then released → exactly one `inc` pulse, 6 edges after the first sample; `dec` stays 0.
- Bounce: key_dec toggles with 1–3 cycle pulses for 20 cycles, then settles high for 10 cycles → one `dec` pulse only, 6 edges after the settle point.
- Hold key_inc for 50 cycles → `inc` pulses at t0, t0+16, t0+24, t0+32, t0+40, t0+48 (6 pulses). No pulse after release.
- Both keys pressed on the same edge and held for 30 cycles → `inc` = `dec` = 0 throughout. Releasing key_dec while key_inc is still held lets only the next scheduled `inc` repeat pulse through.
- rst asserted for 3 cycles mid-hold, key still held → outputs 0 during reset, then one `inc` pulse 6 edges after rst deasserts.
- REPEAT_EN = 0, key held for 50 cycles → exactly one pulse. Release, wait 10 cycles, press again → a second pulse.
